// File: rtl/inj_pkg.sv
// rtl/inj_pkg.sv - shared state encoding and constants for the fault-injection campaign controller
package inj_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST_DUT,
      RUN,
      CHECK,
      DONE
   } state_e;

   localparam logic [1:0] FAULT_NONE = 2'b00;
   localparam logic [1:0] FAULT_Y1   = 2'b01;
   localparam logic [1:0] FAULT_Y2   = 2'b10;
   localparam logic [1:0] FAULT_BOTH = 2'b11;

   // x^6 + x^5 + 1: feedback is q[5] ^ q[4]
   localparam logic [5:0] LFSR_TAPS = 6'b110000;

   localparam int RST_DUT_CYCLES = 2;

endpackage

// File: rtl/inj_lfsr6.sv
// rtl/inj_lfsr6.sv - 6-bit Fibonacci LFSR with seed load and step enable
// Shifts toward the MSB; load has priority over step.
module inj_lfsr6
   import inj_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       load_i,
   input  logic [5:0] seed_i,
   input  logic       step_i,
   output logic [5:0] q_o
);

   logic [5:0] q_q;
   logic [5:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = seed_i;
      end else if (step_i) begin
         q_d = {q_q[4:0], ^(q_q & LFSR_TAPS)};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/injection_campaign_ctrl.sv
// rtl/injection_campaign_ctrl.sv - sequences fault-injection runs on a target/golden pair and counts detected runs
// INJ_LATENCY_EN adds detect_lat_o: cycles from fault strobe to first observed mismatch.
module injection_campaign_ctrl
   import inj_pkg::*;
#(
   parameter int         RUN_LEN   = 32,
   parameter int         RUNS_W    = 8,
   parameter logic [5:0] LFSR_SEED = 6'h2D
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       start_i,
   input  logic [RUNS_W-1:0]          num_runs_i,
   input  logic [$clog2(RUN_LEN)-1:0] inject_cycle_i,
   input  logic [1:0]                 fault_sel_i,
   output logic                       dut_rstn_o,
   output logic [5:0]                 dut_in_o,
   output logic [1:0]                 fault_en_o,
   input  logic [1:0]                 dut_y_i,
   input  logic [1:0]                 gold_y_i,
   output logic                       busy_o,
   output logic                       done_o,
`ifdef INJ_LATENCY_EN
   output logic [$clog2(RUN_LEN):0]   detect_lat_o,
`endif
   output logic [RUNS_W-1:0]          detected_cnt_o
);

   localparam int CYC_W = $clog2(RUN_LEN);
   localparam int RST_W = $clog2(RST_DUT_CYCLES);

   state_e              state_q, state_d;
   logic [CYC_W-1:0]    cyc_q, cyc_d;
   logic [CYC_W-1:0]    inject_q, inject_d;
   logic [RUNS_W-1:0]   run_idx_q, run_idx_d;
   logic [RUNS_W-1:0]   num_runs_q, num_runs_d;
   logic [RUNS_W-1:0]   det_cnt_q, det_cnt_d;
   logic [1:0]          fsel_q, fsel_d;
   logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
   logic                mism_q, mism_d;
   logic                cmp_vld_q;
   logic                lfsr_load;
   logic                lfsr_step;
   logic                mis_now;
   logic                strobe_hit;
   logic [5:0]          lfsr_q;

   inj_lfsr6 u_lfsr (
      .clk    (clk),
      .rstn   (rstn),
      .load_i (lfsr_load),
      .seed_i (LFSR_SEED),
      .step_i (lfsr_step),
      .q_o    (lfsr_q)
   );

   // Outputs lag the stimulus by one cycle, so the compare is qualified by a delayed RUN flag.
   assign mis_now = cmp_vld_q && (dut_y_i != gold_y_i);

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      inject_d   = inject_q;
      run_idx_d  = run_idx_q;
      num_runs_d = num_runs_q;
      det_cnt_d  = det_cnt_q;
      fsel_d     = fsel_q;
      rst_cnt_d  = rst_cnt_q;
      mism_d     = mism_q | mis_now;
      lfsr_load  = 1'b0;
      lfsr_step  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               num_runs_d = num_runs_i;
               inject_d   = inject_cycle_i;
               fsel_d     = fault_sel_i;
               det_cnt_d  = '0;
               run_idx_d  = '0;
               rst_cnt_d  = '0;
               lfsr_load  = 1'b1;
               state_d    = (num_runs_i == '0) ? DONE : RST_DUT;
            end
         end
         RST_DUT: begin
            mism_d    = 1'b0;
            rst_cnt_d = rst_cnt_q + RST_W'(1);
            if (rst_cnt_q == RST_W'(RST_DUT_CYCLES - 1)) begin
               cyc_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            lfsr_step = 1'b1;
            cyc_d     = cyc_q + CYC_W'(1);
            if (cyc_q == CYC_W'(RUN_LEN - 1)) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            // The last RUN cycle's compare lands here, hence mis_now alongside the sticky flag.
            if ((mism_q || mis_now) && !(&det_cnt_q)) begin
               det_cnt_d = det_cnt_q + RUNS_W'(1);
            end
            if (run_idx_q == num_runs_q - RUNS_W'(1)) begin
               state_d = DONE;
            end else begin
               run_idx_d = run_idx_q + RUNS_W'(1);
               rst_cnt_d = '0;
               state_d   = RST_DUT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cyc_q      <= '0;
         inject_q   <= '0;
         run_idx_q  <= '0;
         num_runs_q <= '0;
         det_cnt_q  <= '0;
         fsel_q     <= FAULT_NONE;
         rst_cnt_q  <= '0;
         mism_q     <= 1'b0;
         cmp_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         inject_q   <= inject_d;
         run_idx_q  <= run_idx_d;
         num_runs_q <= num_runs_d;
         det_cnt_q  <= det_cnt_d;
         fsel_q     <= fsel_d;
         rst_cnt_q  <= rst_cnt_d;
         mism_q     <= mism_d;
         cmp_vld_q  <= (state_q == RUN);
      end
   end

   assign strobe_hit     = (state_q == RUN) && (cyc_q == inject_q);
   assign fault_en_o[0]  = strobe_hit && ((fsel_q == FAULT_Y1) || (fsel_q == FAULT_BOTH));
   assign fault_en_o[1]  = strobe_hit && ((fsel_q == FAULT_Y2) || (fsel_q == FAULT_BOTH));
   assign dut_rstn_o     = (state_q == RUN);
   assign dut_in_o       = (state_q == RUN) ? lfsr_q : 6'h00;
   assign busy_o         = (state_q == RST_DUT) || (state_q == RUN) || (state_q == CHECK);
   assign done_o         = (state_q == DONE);
   assign detected_cnt_o = det_cnt_q;

`ifdef INJ_LATENCY_EN
   logic [CYC_W-1:0] cmp_cyc_q;
   logic [CYC_W:0]   lat_q, lat_d;

   // Only the first mismatch of a run is captured; an early mismatch (before the strobe) reports 0.
   always_comb begin
      lat_d = lat_q;
      if (mis_now && !mism_q) begin
         lat_d = (cmp_cyc_q >= inject_q) ? {1'b0, cmp_cyc_q - inject_q} : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cmp_cyc_q <= '0;
         lat_q     <= '0;
      end else begin
         cmp_cyc_q <= cyc_q;
         lat_q     <= lat_d;
      end
   end

   assign detect_lat_o = lat_q;
`endif

endmodule
